// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the Wishbone single-transfer initiator.
package wb_master_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int TIMEOUT_DEF  = 255;
  localparam int TO_CNT_W_DEF = 8;
  localparam int TXN_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack watchdog: counts enabled cycles, flags the cycle whose count equals
// TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 means the flag never rises.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int                  TERM   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_CNT_W-1:0] TERM_V = TO_CNT_W'(TERM);
  localparam logic                TO_ON  = (TIMEOUT_CYCLES > 0);

  logic [TO_CNT_W-1:0] cnt_q;

  // Clear has priority; count only while enabled (bus waiting, no ack).
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc = TO_ON && (cnt_q == TERM_V);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator driven by a cmd/rsp stream,
// with an ack watchdog and a delivered-response counter.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int TO_CNT_W       = TO_CNT_W_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [DATA_W-1:0]     cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  output logic                  busy_o,
  output logic [TXN_CNT_W-1:0]  txn_cnt_o
);

  state_t                state_q, state_d;
  logic                  accept, ack_hit, to_hit, rsp_hs;
  logic                  to_tc;
  logic [TXN_CNT_W-1:0]  txn_cnt_q;

  // Watchdog runs only while the strobe waits; reset on handshake/accept.
  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_wdog (
    .gclk   (wb_clk_i),
    .grst_n (wb_rst_n_i),
    .clr    (accept | rsp_hs),
    .en     ((state_q == BUS) & ~wbm_ack_i),
    .tc     (to_tc)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state and transfer events; ack beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    rsp_hs  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        accept  = 1'b1;
        state_d = BUS;
      end
      BUS: begin
        if (wbm_ack_i) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end else if (to_tc) begin
          to_hit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready_i) begin
        rsp_hs  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

  // Bus side: launch on accept, drop cyc/stb on ack or abort.
  // Address/data/sel/we are left holding the last transfer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (accept) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= cmd_we_i;
      wbm_sel_o <= cmd_sel_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
    end else if (ack_hit | to_hit) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end
  end

  // Response side: load on ack/abort, hold until consumed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else if (ack_hit) begin
      rsp_valid_o <= 1'b1;
      rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
      rsp_err_o   <= 1'b0;
    end else if (to_hit) begin
      rsp_valid_o <= 1'b1;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b1;
    end else if (rsp_hs) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Delivered-response counter, free-running wrap.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)  txn_cnt_q <= '0;
    else if (rsp_hs)  txn_cnt_q <= txn_cnt_q + 1'b1;
  end

  assign txn_cnt_o = txn_cnt_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: stimulus pushes expected responses,
// a monitor pops and compares them on every response handshake.
module tb_wb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [SW-1:0] cmd_sel_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [DW-1:0] rsp_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic          busy_o;
  logic [15:0]   txn_cnt_o;

  always #5 clk = ~clk;

  wb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TO_CNT_W(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o), .txn_cnt_o(txn_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] dat;
    logic          err;
  } rsp_t;
  rsp_t sb_q[$];

  // Slave model controls
  int            ack_delay = 1;   // ack on this strobe cycle; 0 = never
  int            stb_cnt   = 0;   // strobe cycles seen in current transfer
  logic          stray_ack = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  bit            chk_bus   = 1'b0;
  logic          exp_we;
  logic [SW-1:0] exp_sel;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_dat;

  // Slave: react at negedge so ack/data are stable for the next posedge.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && wbm_stb_o) begin
        stb_cnt++;
        if (chk_bus) begin
          check("bus_cyc", wbm_cyc_o, 1);
          check("bus_we",  wbm_we_o,  exp_we);
          check("bus_sel", wbm_sel_o, exp_sel);
          check("bus_adr", wbm_adr_o, exp_adr);
          check("bus_dat", wbm_dat_o, exp_dat);
        end
        wbm_ack_i = (ack_delay > 0) && (stb_cnt == ack_delay);
      end else begin
        wbm_ack_i = stray_ack;
      end
      wbm_dat_i = slv_rdata;
    end
  end

  // Monitor: one compare per response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got dat %0h err %0h expected none", rsp_dat_o, rsp_err_o);
        end else begin
          e = sb_q.pop_front();
          check("rsp_dat", rsp_dat_o, e.dat);
          check("rsp_err", rsp_err_o, e.err);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command and return one tick after the acceptance edge.
  task automatic send(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input bit push,
                      input logic [DW-1:0] rd, input logic err);
    rsp_t e;
    int   k;
    exp_we = we; exp_sel = sel; exp_adr = adr; exp_dat = dat;
    stb_cnt = 0;
    if (push) begin
      e.dat = rd;
      e.err = err;
      sb_q.push_back(e);
    end
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
    k = 0;
    while (!cmd_ready_o && k < 50) begin
      step(1);
      k++;
    end
    if (k == 50) check("cmd_accept_timeout", 0, 1);
    step(1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid_o && k < 50) begin
      step(1);
      k++;
    end
    if (k == 50) check("rsp_wait_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = '0; cmd_adr_i = '0; cmd_dat_i = '0;
    rsp_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    step(2);

    // Reset state
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_txn", txn_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    rst_n = 1'b1;
    step(1);

    // Write, ack on second bus cycle
    chk_bus = 1'b1;
    ack_delay = 2;
    slv_rdata = 32'hDEAD_BEEF;
    send(1'b1, 4'hF, 32'h3000_0000, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
    wait_rsp();
    check("wr_cyc_drop", wbm_cyc_o, 0);
    check("wr_stb_cnt", stb_cnt, 2);
    step(1);
    check("wr_txn", txn_cnt_o, 1);
    check("wr_busy", busy_o, 0);

    // Read, ack on first bus cycle: response two cycles after the command cycle
    ack_delay = 1;
    slv_rdata = 32'h1234_5678;
    send(1'b0, 4'hF, 32'h3000_0004, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    check("rd_bus1_valid", rsp_valid_o, 0);
    check("rd_bus1_stb", wbm_stb_o, 1);
    step(1);
    check("rd_lat_valid", rsp_valid_o, 1);
    check("rd_cyc_drop", wbm_cyc_o, 0);
    check("rd_stb_drop", wbm_stb_o, 0);
    step(1);
    check("rd_txn", txn_cnt_o, 2);
    check("rd_adr_held", wbm_adr_o, 32'h3000_0004);

    // Timeout: slave never acks; stray ack afterwards is ignored
    ack_delay = 0;
    slv_rdata = 32'hCAFE_F00D;
    rsp_ready_i = 1'b0;
    send(1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_rsp();
    check("to_stb_cycles", stb_cnt, TO);
    check("to_err", rsp_err_o, 1);
    check("to_dat", rsp_dat_o, 0);
    stray_ack = 1'b1;
    step(2);
    check("to_stray_valid", rsp_valid_o, 1);
    check("to_stray_err", rsp_err_o, 1);
    check("to_stray_cyc", wbm_cyc_o, 0);
    check("to_stray_busy", busy_o, 1);
    rsp_ready_i = 1'b1;
    step(3);
    check("idle_stray_busy", busy_o, 0);
    check("idle_stray_cyc", wbm_cyc_o, 0);
    check("to_txn", txn_cnt_o, 3);
    stray_ack = 1'b0;

    // Backpressure: response held 10 cycles, second command waits
    ack_delay = 1;
    slv_rdata = 32'h55AA_33CC;
    rsp_ready_i = 1'b0;
    send(1'b0, 4'h3, 32'h3000_000C, 32'h0, 1'b1, 32'h55AA_33CC, 1'b0);
    wait_rsp();
    begin
      rsp_t e;
      e.dat = 32'h0;
      e.err = 1'b0;
      sb_q.push_back(e);
    end
    exp_we = 1'b1; exp_sel = 4'hC; exp_adr = 32'h3000_0010; exp_dat = 32'hBEEF_0000;
    cmd_valid_i = 1'b1;
    cmd_we_i = 1'b1; cmd_sel_i = 4'hC; cmd_adr_i = 32'h3000_0010; cmd_dat_i = 32'hBEEF_0000;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rsp_valid_o, 1);
      check("bp_dat", rsp_dat_o, 32'h55AA_33CC);
      check("bp_err", rsp_err_o, 0);
      check("bp_cmd_ready", cmd_ready_o, 0);
      step(1);
    end
    rsp_ready_i = 1'b1;
    stb_cnt = 0;
    step(1);
    check("bp_hs_ready", cmd_ready_o, 1);
    check("bp_hs_busy", busy_o, 0);
    check("bp_hs_valid", rsp_valid_o, 0);
    check("bp_hs_txn", txn_cnt_o, 4);
    step(1);
    cmd_valid_i = 1'b0;
    check("bp_2nd_busy", busy_o, 1);
    check("bp_2nd_stb", wbm_stb_o, 1);
    wait_rsp();
    step(1);
    check("bp_2nd_txn", txn_cnt_o, 5);

    // Reset while strobe is high
    ack_delay = 0;
    send(1'b1, 4'hF, 32'h3000_0014, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    step(2);
    #2;
    check("mid_pre_stb", wbm_stb_o, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 0);
    check("mid_rst_stb", wbm_stb_o, 0);
    check("mid_rst_valid", rsp_valid_o, 0);
    check("mid_rst_txn", txn_cnt_o, 0);
    check("mid_rst_busy", busy_o, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("post_rst_ready", cmd_ready_o, 1);

    // Counter wrap
    ack_delay = 1;
    slv_rdata = 32'h0BAD_F00D;
    send(1'b0, 4'hF, 32'h3000_0018, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);
    wait_rsp();
    step(1);
    check("post_rst_txn", txn_cnt_o, 1);
    force dut.txn_cnt_q = 16'hFFFF;
    #1;
    release dut.txn_cnt_q;
    send(1'b1, 4'h1, 32'h3000_001C, 32'h0000_0077, 1'b1, 32'h0, 1'b0);
    wait_rsp();
    step(1);
    check("wrap_txn", txn_cnt_o, 16'h0000);

    step(2);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Wishbone classic single-transfer initiator that drives the user-project slave port (user_adder and successors) from a simple command/response stream. Sits on the test/LA side of the user area so firmware-independent logic can issue reads and writes to the slave. Adds an ack timeout watchdog and a completed-transaction counter for bring-up.

Parameters:
ADDR_W, 32, wishbone address width
DATA_W, 32, wishbone data width; sel width is DATA_W/8
TIMEOUT_CYCLES, 255, max cycles with stb high awaiting ack; 0 disables the watchdog
TO_CNT_W, 8, watchdog counter width; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES

Ports:
wb_clk_i  in  1  clock, all logic rising edge
wb_rst_n_i  in  1  reset, asynchronous assert, active-low
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_sel_i  in  DATA_W/8  byte selects
cmd_adr_i  in  ADDR_W  target address
cmd_dat_i  in  DATA_W  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DATA_W  read data (0 for writes and timeouts)
rsp_err_o  out  1  1=transaction timed out
wbm_cyc_o  out  1  wishbone cycle
wbm_stb_o  out  1  wishbone strobe
wbm_we_o  out  1  wishbone write enable
wbm_sel_o  out  DATA_W/8  wishbone byte selects
wbm_adr_o  out  ADDR_W  wishbone address
wbm_dat_o  out  DATA_W  wishbone write data
wbm_ack_i  in  1  wishbone acknowledge
wbm_dat_i  in  DATA_W  wishbone read data
busy_o  out  1  state != IDLE
txn_cnt_o  out  16  count of responses delivered (ack or timeout), wraps 0xFFFF->0

Behaviour:
- Reset (wb_rst_n_i low, async): state IDLE; cyc/stb/we=0; sel/adr/dat_o=0; rsp_valid=0, rsp_dat=0, rsp_err=0; watchdog=0; txn_cnt=0. Asserting reset mid-transfer drops cyc/stb immediately, with no response generated.
- All outputs registered except cmd_ready_o = (state==IDLE) and busy_o.
- FSM states IDLE, BUS, RESP.
- IDLE: on cmd_valid&cmd_ready, capture we/sel/adr/dat onto wbm_* and raise cyc=stb=1 at that edge; go to BUS. First bus cycle is the cycle after acceptance.
- BUS: cyc, stb, adr, sel, we, dat_o held stable. Watchdog increments each BUS cycle without ack.
  - wbm_ack_i=1 sampled: cyc=stb=0 next cycle; rsp_dat = we ? 0 : wbm_dat_i; rsp_err=0; rsp_valid=1; go to RESP. Minimum command-to-response latency is 2 cycles (ack on first bus cycle).
  - Watchdog == TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES>0): abort; cyc=stb=0; rsp_dat=0; rsp_err=1; rsp_valid=1; go to RESP. Stb is therefore high for exactly TIMEOUT_CYCLES cycles.
  - Ack in the same cycle as the timeout threshold: the ack wins, giving a normal response.
- RESP: rsp_* held stable until rsp_ready_i. On handshake: rsp_valid=0, txn_cnt+1, watchdog=0, go to IDLE. cmd_ready is low throughout RESP, so there is no back-to-back overlap: the next command is accepted no earlier than the cycle after the response handshake.
- wbm_ack_i outside BUS is ignored, with no state change.
- wbm_dat_o/adr/sel/we keep their last values after cycle end (not cleared).
- Only one transfer is outstanding. No pipelining, retry, err_i or burst support.

Decomposition:
- Package wb_master_pkg: state enum (IDLE, BUS, RESP), default widths, TXN_CNT_W=16.
- One sub-module, wb_timeout_ctr: clear/enable/terminal-count watchdog parameterised by TIMEOUT_CYCLES and TO_CNT_W. Everything else lives in the top module.

Test Plan:
- Write: cmd we=1, adr=0x3000_0000, dat=0x0000_00A5, sel=0xF; slave acks on bus cycle 2 -> wbm_* match the command while stb high; response rsp_err=0, rsp_dat=0; txn_cnt=1.
- Read: adr=0x3000_0004; slave returns 0x1234_5678 with ack on first bus cycle -> rsp_valid 2 cycles after acceptance; rsp_dat=0x1234_5678; cyc drops the cycle after ack.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0; ack after abort is ignored.
- Backpressure: rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready=0, second cmd_valid not accepted until the cycle after the handshake.
- Reset mid-BUS: drop wb_rst_n_i while stb=1 -> cyc/stb=0 without a clock edge, rsp_valid=0, txn_cnt=0; after release, cmd_ready=1.
- Counter wrap: force 0xFFFF completions (or preload via hierarchical force) -> next response gives txn_cnt=0x0000.
